// File: rtl/seg7_pkg.sv
// Shared constants, types and small helpers for the six-digit seven-segment scan controller.
package seg7_pkg;

    localparam int         NDIG        = 6;
    localparam logic [3:0] SEG7_BLANK  = 4'hF;
    localparam int         DEAD_CYCLES = 1;

    typedef logic [2:0] dig_idx_t;

    localparam dig_idx_t LAST_DIG = dig_idx_t'(NDIG - 1);

    // Everything captured once per frame so a frame is drawn from one coherent set of inputs.
    typedef struct packed {
        logic [NDIG*4-1:0] bcd;
        logic [NDIG-1:0]   blink_mask;
        logic [NDIG-1:0]   dp_mask;
        logic              blank_lz;
    } snap_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [3:0] digit_of(input logic [NDIG*4-1:0] bcd, input dig_idx_t i);
        logic [3:0] d;
        d = SEG7_BLANK;
        for (int k = 0; k < NDIG; k++) begin
            if (i == dig_idx_t'(k)) d = bcd[4*k +: 4];
        end
        return d;
    endfunction

    function automatic logic bit_of(input logic [NDIG-1:0] mask, input dig_idx_t i);
        logic b;
        b = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (i == dig_idx_t'(k)) b = mask[k];
        end
        return b;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle of the scan controller: digit data and masks in, decoder/select drive out.
interface seg7_scan_ctrl_if;

    logic                         en;
    logic [seg7_pkg::NDIG*4-1:0]  bcd_in;
    logic [seg7_pkg::NDIG-1:0]    blink_mask;
    logic [seg7_pkg::NDIG-1:0]    dp_mask;
    logic                         blank_lz;
    logic [3:0]                   num;
    logic [seg7_pkg::NDIG-1:0]    dig_sel_n;
    logic                         dp_n;
    logic                         frame_tick;

    modport master (
        output en, bcd_in, blink_mask, dp_mask, blank_lz,
        input  num, dig_sel_n, dp_n, frame_tick
    );

    modport slave (
        input  en, bcd_in, blink_mask, dp_mask, blank_lz,
        output num, dig_sel_n, dp_n, frame_tick
    );

endinterface

// File: rtl/scan_prescaler.sv
// Slot/digit sequencer: cycle counter within a slot, digit index, frame-start strobe and frame_tick.
module scan_prescaler
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output dig_idx_t         idx,
    output logic             frame_start,
    output logic             frame_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    dig_idx_t         idx_q, idx_d;
    logic             frame_tick_q, frame_tick_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        frame_start  = en && (cnt_q == '0) && (idx_q == '0);
        frame_tick_d = frame_start;
        if (!en) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == LAST_DIG) ? dig_idx_t'(0) : idx_q + dig_idx_t'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign cnt        = cnt_q;
    assign idx        = idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Six-digit time-multiplexed display scanner: per-frame snapshot, blink, leading-zero blank, dp, dead time.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input logic             clk,
    input logic             rst,
    seg7_scan_ctrl_if.slave bus
);

    localparam int                 CNT_W     = cnt_width(SCAN_DIV);
    localparam int                 BFRM_W    = cnt_width(BLINK_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_DEAD  = CNT_W'(DEAD_CYCLES);
    localparam logic [BFRM_W-1:0]  BFRM_LAST = BFRM_W'(BLINK_FRAMES - 1);
    localparam logic [NDIG-1:0]    SEL_ONE   = NDIG'(1);

    logic [CNT_W-1:0] cnt;
    dig_idx_t         idx;
    logic             frame_start;
    logic             frame_tick;

    snap_t             snap_in, snap_q, snap_d;
    logic [BFRM_W-1:0] bfrm_q, bfrm_d;
    logic              bphase_q, bphase_d;
    logic              blink_off_q, blink_off_d;
    logic              blink_off_cur;
    logic [3:0]        digit;
    logic [3:0]        num_q, num_d;
    logic [NDIG-1:0]   dig_sel_n_q, dig_sel_n_d;
    logic              dp_n_q, dp_n_d;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk         (clk),
        .rst         (rst),
        .en          (bus.en),
        .cnt         (cnt),
        .idx         (idx),
        .frame_start (frame_start),
        .frame_tick  (frame_tick)
    );

    // bphase advances for the next frame; blink_off holds the phase the current frame is drawn with.
    always_comb begin
        snap_in     = '{bcd: bus.bcd_in, blink_mask: bus.blink_mask,
                        dp_mask: bus.dp_mask, blank_lz: bus.blank_lz};
        snap_d      = snap_q;
        bfrm_d      = bfrm_q;
        bphase_d    = bphase_q;
        blink_off_d = blink_off_q;
        if (!bus.en) begin
            bfrm_d      = '0;
            bphase_d    = 1'b0;
            blink_off_d = 1'b0;
        end else if (frame_start) begin
            snap_d      = snap_in;
            blink_off_d = bphase_q;
            if (bfrm_q == BFRM_LAST) begin
                bfrm_d   = '0;
                bphase_d = ~bphase_q;
            end else begin
                bfrm_d = bfrm_q + BFRM_W'(1);
            end
        end
    end

    // The frame-start cycle already draws from the values being captured, so a frame never mixes old and new data.
    always_comb begin
        blink_off_cur = frame_start ? bphase_q : blink_off_q;
        digit         = digit_of(snap_d.bcd, idx);
        num_d         = SEG7_BLANK;
        dig_sel_n_d   = '1;
        dp_n_d        = 1'b1;
        if (bus.en) begin
            if (blink_off_cur && bit_of(snap_d.blink_mask, idx)) begin
                num_d = SEG7_BLANK;
            end else if (idx == LAST_DIG && snap_d.blank_lz && digit == 4'd0) begin
                num_d = SEG7_BLANK;
            end else begin
                num_d = digit;
            end
            if (cnt >= CNT_DEAD) begin
                dig_sel_n_d = ~(SEL_ONE << idx);
                dp_n_d      = ~bit_of(snap_d.dp_mask, idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the snapshot is cleared by reset only; dropping en deliberately leaves it untouched.
            snap_q      <= '0;
            bfrm_q      <= '0;
            bphase_q    <= 1'b0;
            blink_off_q <= 1'b0;
            num_q       <= SEG7_BLANK;
            dig_sel_n_q <= '1;
            dp_n_q      <= 1'b1;
        end else begin
            snap_q      <= snap_d;
            bfrm_q      <= bfrm_d;
            bphase_q    <= bphase_d;
            blink_off_q <= blink_off_d;
            num_q       <= num_d;
            dig_sel_n_q <= dig_sel_n_d;
            dp_n_q      <= dp_n_d;
        end
    end

    assign bus.num        = num_q;
    assign bus.dig_sel_n  = dig_sel_n_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-arithmetic reference model queues expected outputs, a monitor compares.
module tb_seg7_scan_ctrl;
    import seg7_pkg::*;

    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = NDIG * SD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if bus ();

    seg7_scan_ctrl #(
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         due;
        logic [3:0] num;
        logic [5:0] sel;
        logic       dp;
        logic       tick;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: position in the frame is plain cycle arithmetic since the last restart.
    int          t       = 0;
    logic [23:0] m_bcd   = '0;
    logic [5:0]  m_blink = '0;
    logic [5:0]  m_dp    = '0;
    logic        m_lz    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    function automatic logic [19:0] pk(input logic [3:0] n, input logic [5:0] s, input logic d, input logic k);
        return {n, 2'b00, s, 3'b000, d, 3'b000, k};
    endfunction

    task automatic model(input logic r, input logic e, input logic [23:0] b, input logic [5:0] bm,
                         input logic [5:0] dm, input logic lz, output exp_t x);
        int pos, f, di, off;
        logic [3:0] d;
        x.due = 0; x.num = 4'hF; x.sel = 6'h3F; x.dp = 1'b1; x.tick = 1'b0;
        if (r) begin
            t = 0; m_bcd = '0; m_blink = '0; m_dp = '0; m_lz = 1'b0;
        end else if (!e) begin
            t = 0;
        end else begin
            pos = t % FRAME;
            f   = t / FRAME;
            di  = pos / SD;
            off = pos % SD;
            if (pos == 0) begin
                m_bcd = b; m_blink = bm; m_dp = dm; m_lz = lz;
            end
            d = 4'(m_bcd >> (4 * di));
            if (((f / BF) % 2) == 1 && m_blink[di]) x.num = 4'hF;
            else if (di == 5 && m_lz && d == 4'd0)   x.num = 4'hF;
            else                                     x.num = d;
            if (off != 0) begin
                x.sel = 6'h3F ^ (6'd1 << di);
                x.dp  = ~m_dp[di];
            end
            x.tick = (pos == 0);
            t++;
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [23:0] b, input logic [5:0] bm,
                         input logic [5:0] dm, input logic lz);
        exp_t x;
        rst = r; bus.en = e; bus.bcd_in = b; bus.blink_mask = bm; bus.dp_mask = dm; bus.blank_lz = lz;
        model(r, e, b, bm, dm, lz, x);
        x.due = cyc + 1;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic r, input logic e, input logic [23:0] b,
                       input logic [5:0] bm, input logic [5:0] dm, input logic lz);
        for (int i = 0; i < n; i++) drive(r, e, b, bm, dm, lz);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                x = sb.pop_front();
                check($sformatf("out@cyc%0d num|sel|dp|tick", cyc),
                      32'(pk(bus.num, bus.dig_sel_n, bus.dp_n, bus.frame_tick)),
                      32'(pk(x.num, x.sel, x.dp, x.tick)));
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: run did not finish, got %0d cycles, required under 200000", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int len;
        logic r, e;
        bus.en = 1'b0; bus.bcd_in = '0; bus.blink_mask = '0; bus.dp_mask = '0; bus.blank_lz = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++)
            drive(1'b1, 1'($urandom), 24'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));

        run(48, 1'b0, 1'b1, 24'h123456, 6'h00, 6'h00, 1'b0);

        run(1, 1'b1, 1'b0, 24'h0, 6'h00, 6'h00, 1'b0);
        run(9, 1'b0, 1'b1, 24'h123456, 6'h00, 6'h00, 1'b0);
        run(39, 1'b0, 1'b1, 24'h000000, 6'h00, 6'h00, 1'b0);

        run(1, 1'b1, 1'b0, 24'h0, 6'h00, 6'h00, 1'b0);
        run(24, 1'b0, 1'b1, 24'h093000, 6'h00, 6'h00, 1'b1);
        run(24, 1'b0, 1'b1, 24'h193000, 6'h00, 6'h00, 1'b1);

        run(1, 1'b1, 1'b0, 24'h0, 6'h00, 6'h00, 1'b0);
        run(6 * FRAME, 1'b0, 1'b1, 24'h123456, 6'b110000, 6'b010100, 1'b0);

        run(1, 1'b1, 1'b0, 24'h0, 6'h00, 6'h00, 1'b0);
        run(14, 1'b0, 1'b1, 24'h654321, 6'h00, 6'h3F, 1'b0);
        run(1, 1'b1, 1'b1, 24'h654321, 6'h00, 6'h3F, 1'b0);
        run(24, 1'b0, 1'b1, 24'h654321, 6'h00, 6'h3F, 1'b0);
        run(14, 1'b0, 1'b1, 24'h987654, 6'h21, 6'h12, 1'b0);
        run(1, 1'b0, 1'b0, 24'h987654, 6'h21, 6'h12, 1'b0);
        run(24, 1'b0, 1'b1, 24'h987654, 6'h21, 6'h12, 1'b0);

        for (int k = 0; k < 40; k++) begin
            r   = ($urandom_range(0, 15) == 0);
            e   = ($urandom_range(0, 7) != 0);
            len = r ? 1 : $urandom_range(1, 120);
            run(len, r, e, 24'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));
        end

        @(negedge clk);
        #1;
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the alarm clock's six-digit common-anode display (HH:MM:SS). It snapshots six BCD digits once per frame and drives one digit at a time onto the single shared BCD-to-seven-segment decoder `num_to_seg7_0_9`, together with the matching active-low digit select. It also applies per-digit blinking (edit mode), hour-tens leading-zero blanking, and per-digit decimal points. The decoder sits outside this block; this block drives its `num` input.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot; legal range ≥ 2.
- `BLINK_FRAMES`, 64: frames per blink half-period; legal range ≥ 1.
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: scan enable; 0 turns all digits off and holds counters at 0.
- `bcd_in` in 24: digit i occupies `[4i+3:4i]`; i=0 is seconds units, i=5 is hours tens.
- `blink_mask` in 6: 1 means digit i blanks during the blink-off phase.
- `dp_mask` in 6: 1 lights the decimal point on digit i.
- `blank_lz` in 1: 1 blanks digit 5 when its value is 0.
- `num` out 4: digit code to the decoder; 4'hF is the blank code.
- `dig_sel_n` out 6: active-low digit select, one-hot-low or all ones.
- `dp_n` out 1: active-low decimal point for the selected digit.
- `frame_tick` out 1: one-cycle pulse at the start of each frame.

## Operation
- State:
  - `cnt`, 0..SCAN_DIV-1: slot cycle counter.
  - `idx`, 0..5: current digit.
  - `bfrm`, 0..BLINK_FRAMES-1: blink frame counter.
  - `bphase`: 0 = visible, 1 = blink-off.
  - Snapshot registers for `bcd_in`, `blink_mask`, `dp_mask` and `blank_lz`.
- Slot sequencing:
  - `cnt` increments every cycle while `en`=1.
  - At `cnt`=SCAN_DIV-1, `cnt`→0 and `idx`→idx+1; `idx`=5 wraps to 0.
- Frame start is the transition to `idx`=0, `cnt`=0. On frame start:
  - Snapshot all data inputs.
  - Pulse `frame_tick`.
  - Advance `bfrm`; when `bfrm` wraps, toggle `bphase`.
- Input changes mid-frame are invisible until the next frame start.
- Digit value for the current `idx`, in priority order:
  - 4'hF if `bphase`=1 and `blink_mask[idx]`=1.
  - Otherwise 4'hF if `idx`=5, `blank_lz`=1 and the snapshot digit is 0.
  - Otherwise the snapshot digit, passed unchanged; non-BCD codes 10–15 are passed through and the decoder blanks them.
- Dead time: in the cycle a slot begins (`cnt`=0), `dig_sel_n`=6'h3F and `dp_n`=1, which suppresses ghosting.
- Lit cycles (`cnt`≥1):
  - `dig_sel_n[idx]`=0.
  - `dp_n`=~`dp_mask[idx]`; dp is not affected by blink.
- `en`=0:
  - Outputs take their reset values.
  - `cnt`, `idx` and `bfrm` clear; `bphase` clears.
  - Snapshots hold.
  - When `en` returns to 1, the first cycle is a frame start.
- Reset values:
  - `num`=4'hF, `dig_sel_n`=6'h3F, `dp_n`=1, `frame_tick`=0.
  - All counters 0, `bphase`=0, snapshots 0.
- The first active cycle after reset release with `en`=1 is a frame start. Therefore `bcd_in` is captured in that cycle.

## Timing
- All outputs are registered. They reflect the `cnt`/`idx` state of the previous cycle, so there is a fixed 1-cycle output latency.
- Slot = SCAN_DIV cycles: 1 dark cycle, then SCAN_DIV-1 lit cycles.
- Frame = 6·SCAN_DIV cycles.
- `frame_tick` is high for exactly one cycle per frame, aligned with the dark cycle of digit 0.
- Blink period = 2·BLINK_FRAMES frames.
- `rst` dominates `en`. Asserting `rst` mid-slot forces reset values at the next edge, with no completion of the current slot.

## Structure
- Shared package `seg7_pkg` holds:
  - `NDIG`=6
  - `SEG7_BLANK`=4'hF
  - the digit-index typedef (3 bits)
  - the dead-time cycle count, fixed at 1
- One sub-module is natural: `scan_prescaler`. It holds the `cnt`/`idx` counters and generates `frame_tick`.
- The blink logic, snapshot registers and output mux stay in the top level.

## Test plan
All scenarios use SCAN_DIV=4 and BLINK_FRAMES=2.
- Reset: hold `rst`=1 with random inputs → `num`=F, `dig_sel_n`=3F, `dp_n`=1, `frame_tick`=0 every cycle.
- Scan order: `bcd_in`=24'h123456, all masks 0, `en`=1.
  - Each slot shows 1 dark cycle, then 3 cycles of (num, `dig_sel_n`): (6, 3E), (5, 3D), (4, 3B), (3, 37), (2, 2F), (1, 1F).
  - `frame_tick` pulses every 24 cycles.
- Snapshot: change `bcd_in` to 24'h000000 during the digit 2 slot → digits 3–5 still show 3, 2, 1; the next frame shows all 0.
- Leading zero: `blank_lz`=1.
  - `bcd_in`=24'h093000 → digit 5 `num`=F, digit 4 `num`=9.
  - `bcd_in`=24'h193000 → digit 5 `num`=1.
- Blink and dp: `blink_mask`=6'b110000, `dp_mask`=6'b010100.
  - Frames 0–1: digits 5 and 4 visible.
  - Frames 2–3: digits 5 and 4 show `num`=F.
  - Frames 4–5: digits 5 and 4 visible again.
  - `dp_n`=0 on the lit cycles of digits 2 and 4 in every frame.
- Mid-operation abort: assert `rst` during the digit 3 slot → reset values on the next cycle; after release, digit 0 starts with a dark cycle. Repeat with `en`=0 → same response, with snapshots retained.
